// File: rtl/ctrl_seq_pkg.sv
// Shared types for the accumulator CPU: opcode set, sequencer phase encoding
// and the control strobe bundle.
package ctrl_seq_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned PHASE_W  = 3;

   typedef enum logic [OPCODE_W-1:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } state_t;

   typedef struct packed {
      logic mem_rd;
      logic mem_wr;
      logic load_ir;
      logic load_ac;
      logic load_pc;
      logic inc_pc;
      logic halt;
      logic data_e;
      logic sel;
   } strobes_t;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_aluop(opcode_t op);
      return op inside {ADD, AND, XOR, LDA};
   endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> datapath control bundle: decoded opcode and zero flag in,
// memory/register strobes and debug phase out.
interface ctrl_seq_if;
   import ctrl_seq_pkg::*;

   opcode_t opcode;
   logic    zero;
   logic    mem_rd;
   logic    mem_wr;
   logic    load_ir;
   logic    load_ac;
   logic    load_pc;
   logic    inc_pc;
   logic    halt;
   logic    data_e;
   logic    sel;
   state_t  phase;

   modport master (
      input  opcode, zero,
      output mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, data_e, sel, phase
   );

   modport slave (
      output opcode, zero,
      input  mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, data_e, sel, phase
   );

endinterface

// File: rtl/ctrl_seq.sv
// Instruction sequencer: walks each instruction through eight phases and
// decodes (phase, opcode, zero) into datapath strobes with no added latency.
module ctrl_seq
   import ctrl_seq_pkg::*;
(
   input  logic      clk,
   input  logic      rst_,
   ctrl_seq_if.master bus
);

   state_t   phase_q, phase_d;
   logic     halted_q, halted_d;
   strobes_t strobe_c;
   logic     aluop_c;

   assign aluop_c = is_aluop(bus.opcode);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Next phase and strobe decode; halted state overrides everything but halt.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      strobe_c = '0;
      if (halted_q) begin
         strobe_c.halt = 1'b1;
      end else begin
         case (phase_q)
            INST_ADDR: begin
               strobe_c.sel = 1'b1;
               phase_d      = INST_FETCH;
            end
            INST_FETCH: begin
               strobe_c.sel    = 1'b1;
               strobe_c.mem_rd = 1'b1;
               phase_d         = INST_LOAD;
            end
            INST_LOAD: begin
               strobe_c.sel     = 1'b1;
               strobe_c.mem_rd  = 1'b1;
               strobe_c.load_ir = 1'b1;
               phase_d          = IDLE;
            end
            IDLE: begin
               strobe_c.sel     = 1'b1;
               strobe_c.mem_rd  = 1'b1;
               strobe_c.load_ir = 1'b1;
               phase_d          = OP_ADDR;
            end
            OP_ADDR: begin
               strobe_c.inc_pc = 1'b1;
               if (bus.opcode == HLT) begin
                  strobe_c.halt = 1'b1;
                  halted_d      = 1'b1;
               end else begin
                  phase_d = OP_FETCH;
               end
            end
            OP_FETCH: begin
               strobe_c.mem_rd = aluop_c;
               phase_d         = ALU_OP;
            end
            ALU_OP: begin
               strobe_c.mem_rd  = aluop_c;
               strobe_c.inc_pc  = (bus.opcode == SKZ) && bus.zero;
               strobe_c.load_pc = (bus.opcode == JMP);
               strobe_c.data_e  = (bus.opcode == STO);
               phase_d          = STORE;
            end
            STORE: begin
               strobe_c.mem_rd  = aluop_c;
               strobe_c.inc_pc  = (bus.opcode == JMP);
               strobe_c.load_ac = aluop_c;
               strobe_c.load_pc = (bus.opcode == JMP);
               strobe_c.mem_wr  = (bus.opcode == STO);
               strobe_c.data_e  = (bus.opcode == STO);
               phase_d          = INST_ADDR;
            end
            default: phase_d = INST_ADDR;
         endcase
      end
   end

   assign bus.mem_rd  = strobe_c.mem_rd;
   assign bus.mem_wr  = strobe_c.mem_wr;
   assign bus.load_ir = strobe_c.load_ir;
   assign bus.load_ac = strobe_c.load_ac;
   assign bus.load_pc = strobe_c.load_pc;
   assign bus.inc_pc  = strobe_c.inc_pc;
   assign bus.halt    = strobe_c.halt;
   assign bus.data_e  = strobe_c.data_e;
   assign bus.sel     = strobe_c.sel;
   assign bus.phase   = phase_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-phase vector table for whole instructions,
// plus hand sequences for async reset mid-instruction and HLT.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   // Strobe vector bit order: mem_rd mem_wr load_ir load_ac load_pc inc_pc halt data_e sel
   localparam logic [8:0] S_NONE  = 9'b000000000;
   localparam logic [8:0] S_SEL   = 9'b000000001;
   localparam logic [8:0] S_FETCH = 9'b100000001;
   localparam logic [8:0] S_LOAD  = 9'b101000001;
   localparam logic [8:0] S_OPADR = 9'b000001000;

   typedef struct {
      string      name;
      opcode_t    op;
      logic       z;
      state_t     ph;
      logic [8:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_;
   int   n_pass = 0;
   int   n_total = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   ctrl_seq_if bus ();

   ctrl_seq dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   function automatic logic [8:0] strobes();
      return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac, bus.load_pc,
              bus.inc_pc, bus.halt, bus.data_e, bus.sel};
   endfunction

   task automatic check(string tag, state_t exp_ph, logic [8:0] exp_s);
      logic [8:0] act;
      act = strobes();
      n_total++;
      if (bus.phase === exp_ph) n_pass++;
      else $display("FAIL %s phase: got %0d want %0d", tag, bus.phase, exp_ph);
      n_total++;
      if (act === exp_s) n_pass++;
      else $display("FAIL %s strobes: got %b want %b", tag, act, exp_s);
   endtask

   function automatic void add(string n, opcode_t op, logic z, state_t ph, logic [8:0] e);
      vec_t v;
      v.name = n; v.op = op; v.z = z; v.ph = ph; v.exp = e;
      vecs.push_back(v);
   endfunction

   // One full instruction; z_alu is the zero flag during ALU_OP, z_oth elsewhere.
   function automatic void add_instr(string n, opcode_t op, logic z_alu, logic z_oth,
                                     logic [8:0] e_fetch, logic [8:0] e_alu, logic [8:0] e_store);
      add({n, "/inst_addr"},  op, z_oth, INST_ADDR,  S_SEL);
      add({n, "/inst_fetch"}, op, z_oth, INST_FETCH, S_FETCH);
      add({n, "/inst_load"},  op, z_oth, INST_LOAD,  S_LOAD);
      add({n, "/idle"},       op, z_oth, IDLE,       S_LOAD);
      add({n, "/op_addr"},    op, z_oth, OP_ADDR,    S_OPADR);
      add({n, "/op_fetch"},   op, z_oth, OP_FETCH,   e_fetch);
      add({n, "/alu_op"},     op, z_alu, ALU_OP,     e_alu);
      add({n, "/store"},      op, z_oth, STORE,      e_store);
   endfunction

   initial begin
      add_instr("add",  ADD, 1'b0, 1'b0, 9'b100000000, 9'b100000000, 9'b100100000);
      add_instr("lda",  LDA, 1'b1, 1'b1, 9'b100000000, 9'b100000000, 9'b100100000);
      add_instr("xor",  XOR, 1'b0, 1'b1, 9'b100000000, 9'b100000000, 9'b100100000);
      add_instr("sto",  STO, 1'b0, 1'b0, S_NONE,       9'b000000010, 9'b010000010);
      add_instr("skz1", SKZ, 1'b1, 1'b1, S_NONE,       9'b000001000, S_NONE);
      add_instr("skz0", SKZ, 1'b0, 1'b1, S_NONE,       S_NONE,       S_NONE);
      add_instr("jmp",  JMP, 1'b0, 1'b0, S_NONE,       9'b000010000, 9'b000011000);

      rst_       = 1'b0;
      bus.opcode = ADD;
      bus.zero   = 1'b0;
      #1;
      check("reset", INST_ADDR, S_SEL);
      repeat (2) @(negedge clk);
      check("reset_held", INST_ADDR, S_SEL);
      rst_ = 1'b1;

      foreach (vecs[i]) begin
         bus.opcode = vecs[i].op;
         bus.zero   = vecs[i].z;
         #1;
         check(vecs[i].name, vecs[i].ph, vecs[i].exp);
         @(negedge clk);
      end

      // STO aborted by reset in ALU_OP: no mem_wr may follow
      bus.opcode = STO;
      bus.zero   = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("sto_abort/alu_op", ALU_OP, 9'b000000010);
      #2 rst_ = 1'b0;
      #1;
      check("sto_abort/async", INST_ADDR, S_SEL);
      @(posedge clk);
      #1;
      check("sto_abort/held", INST_ADDR, S_SEL);
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk);
      #1;
      check("sto_abort/resume", INST_FETCH, S_FETCH);

      // HLT freezes in OP_ADDR until reset
      @(negedge clk);
      rst_ = 1'b0;
      @(negedge clk);
      rst_       = 1'b1;
      bus.opcode = HLT;
      repeat (4) @(negedge clk);
      #1;
      check("hlt/op_addr", OP_ADDR, 9'b000001100);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.opcode = (k % 2 == 0) ? ADD : JMP;
         bus.zero   = k[0];
         #1;
         check($sformatf("hlt/frozen%0d", k), OP_ADDR, 9'b000000100);
      end
      rst_ = 1'b0;
      #1;
      check("hlt/reset", INST_ADDR, S_SEL);
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk);
      #1;
      check("hlt/resume", INST_FETCH, S_FETCH);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
